// File: rtl/axil_wr_arbiter.sv
// AXI-Lite write-channel arbiter: grants one master at a time and holds the grant
// through the address/data phase and the write response.
module axil_wr_arbiter #(
    parameter int unsigned NUMBER_MASTER = 32,
    parameter int unsigned ARBITER       = 1,
    parameter int unsigned IDX_W         = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUMBER_MASTER-1:0] req,
    input  logic                     aw_hs,
    input  logic                     w_hs,
    input  logic                     b_hs,
    output logic [NUMBER_MASTER-1:0] grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     grant_valid
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2
    } state_t;

    state_t                   state_q;
    logic [NUMBER_MASTER-1:0] grant_q;
    logic [IDX_W-1:0]         grant_idx_q;
    logic                     grant_valid_q;
    logic [IDX_W-1:0]         rr_ptr_q;
    logic                     aw_done_q;
    logic                     w_done_q;

    logic [IDX_W-1:0]         win_idx_d;
    logic [NUMBER_MASTER-1:0] win_oh_d;
    logic [IDX_W-1:0]         rr_ptr_d;
    logic                     any_req;
    logic                     aw_seen;
    logic                     w_seen;
    logic                     found;
    int unsigned              cand;
    logic [NUMBER_MASTER-1:0] req_sh;

    // Scan NUMBER_MASTER candidates starting at rr_ptr (or 0 for fixed priority),
    // wrapping so that non-power-of-two master counts rotate correctly.
    always_comb begin
        win_idx_d = '0;
        found     = 1'b0;
        cand      = 0;
        req_sh    = '0;
        for (int unsigned i = 0; i < NUMBER_MASTER; i++) begin
            cand = i;
            if (ARBITER != 0) begin
                cand = cand + 32'(rr_ptr_q);
            end
            if (cand >= NUMBER_MASTER) begin
                cand = cand - NUMBER_MASTER;
            end
            req_sh = req >> cand;
            if (!found && req_sh[0]) begin
                found     = 1'b1;
                win_idx_d = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        any_req  = |req;
        win_oh_d = NUMBER_MASTER'(1) << win_idx_d;
        rr_ptr_d = (grant_idx_q == IDX_W'(NUMBER_MASTER - 1)) ? '0 : grant_idx_q + 1'b1;
        aw_seen  = aw_done_q | aw_hs;
        w_seen   = w_done_q | w_hs;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q       <= win_oh_d;
                        grant_idx_q   <= win_idx_d;
                        grant_valid_q <= 1'b1;
                        state_q       <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (aw_seen && w_seen) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= RESP;
                    end else begin
                        aw_done_q <= aw_seen;
                        w_done_q  <= w_seen;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        grant_q       <= '0;
                        grant_idx_q   <= '0;
                        grant_valid_q <= 1'b0;
                        rr_ptr_q      <= rr_ptr_d;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share every input and
// are checked against hand-derived grant sequences plus a per-cycle invariant.
module tb_axil_wr_arbiter;

    localparam int unsigned N = 4;

    logic         aclk;
    logic         aresetn;
    logic [N-1:0] req;
    logic         aw_hs;
    logic         w_hs;
    logic         b_hs;

    logic [N-1:0] g_rr, g_fp;
    logic [1:0]   gi_rr, gi_fp;
    logic         gv_rr, gv_fp;

    int checks;
    int errors;

    axil_wr_arbiter #(.NUMBER_MASTER(N), .ARBITER(1)) dut_rr (
        .aclk(aclk), .aresetn(aresetn), .req(req),
        .aw_hs(aw_hs), .w_hs(w_hs), .b_hs(b_hs),
        .grant(g_rr), .grant_idx(gi_rr), .grant_valid(gv_rr)
    );

    axil_wr_arbiter #(.NUMBER_MASTER(N), .ARBITER(0)) dut_fp (
        .aclk(aclk), .aresetn(aresetn), .req(req),
        .aw_hs(aw_hs), .w_hs(w_hs), .b_hs(b_hs),
        .grant(g_fp), .grant_idx(gi_fp), .grant_valid(gv_fp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic inv(input string tag, input logic [N-1:0] g, input logic [1:0] gi, input logic gv);
        chk({tag, "_valid_eq_any"}, 32'(gv), 32'(|g));
        chk({tag, "_onehot0"}, 32'($onehot0(g)), 32'd1);
        chk({tag, "_grant_vs_idx"}, 32'(g), gv ? (32'd1 << gi) : 32'd0);
        if (!gv) chk({tag, "_idx_zero"}, 32'(gi), 32'd0);
    endtask

    always @(negedge aclk) begin
        inv("inv_rr", g_rr, gi_rr, gv_rr);
        inv("inv_fp", g_fp, gi_fp, gv_fp);
    end

    task automatic grant_chk(input string tag, input int exp_rr, input int exp_fp);
        tick();
        chk({tag, "_rr_valid"}, 32'(gv_rr), 32'd1);
        chk({tag, "_rr_idx"}, 32'(gi_rr), 32'(exp_rr));
        chk({tag, "_rr_grant"}, 32'(g_rr), 32'd1 << exp_rr);
        chk({tag, "_fp_valid"}, 32'(gv_fp), 32'd1);
        chk({tag, "_fp_idx"}, 32'(gi_fp), 32'(exp_fp));
    endtask

    task automatic complete(input string tag);
        aw_hs = 1'b1;
        w_hs  = 1'b1;
        tick();
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        b_hs  = 1'b1;
        tick();
        b_hs  = 1'b0;
        chk({tag, "_rr_released"}, 32'(gv_rr), 32'd0);
        chk({tag, "_fp_released"}, 32'(gv_fp), 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        aresetn = 1'b0;
        req     = '0;
        aw_hs   = 1'b0;
        w_hs    = 1'b0;
        b_hs    = 1'b0;

        tick();
        tick();
        chk("rst_rr_valid", 32'(gv_rr), 32'd0);
        chk("rst_rr_grant", 32'(g_rr), 32'd0);
        chk("rst_rr_idx", 32'(gi_rr), 32'd0);
        chk("rst_fp_valid", 32'(gv_fp), 32'd0);

        aresetn = 1'b1;
        tick();
        chk("idle_noreq", 32'(gv_rr), 32'd0);
        aw_hs = 1'b1;
        w_hs  = 1'b1;
        b_hs  = 1'b1;
        tick();
        chk("idle_hs_ignored_rr", 32'(gv_rr), 32'd0);
        chk("idle_hs_ignored_fp", 32'(gv_fp), 32'd0);
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        b_hs  = 1'b0;

        // Round robin over all four requesters, wrapping back to 0.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            grant_chk("rr_all", k % 4, 0);
            complete("rr_all");
        end

        // rr_ptr is 1 here: both pick 1, then rr moves to 3 while fp stays at 1.
        req = 4'b1010;
        grant_chk("mix1", 1, 1);
        complete("mix1");
        grant_chk("mix2", 3, 1);
        complete("mix2");

        // W early, AW three cycles later, B two cycles after that.
        req = 4'b0100;
        grant_chk("late_aw", 2, 2);
        w_hs = 1'b1;
        tick();
        w_hs = 1'b0;
        tick();
        tick();
        chk("late_aw_still_addr", 32'(dut_rr.state_q), 32'd1);
        chk("late_aw_valid", 32'(gv_rr), 32'd1);
        aw_hs = 1'b1;
        tick();
        aw_hs = 1'b0;
        chk("late_aw_resp", 32'(dut_rr.state_q), 32'd2);
        tick();
        chk("late_aw_resp_hold", 32'(gv_rr), 32'd1);
        chk("late_aw_resp_state", 32'(dut_fp.state_q), 32'd2);
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        chk("late_aw_rel_valid", 32'(gv_rr), 32'd0);
        chk("late_aw_rel_grant", 32'(g_rr), 32'd0);
        chk("late_aw_rel_idx", 32'(gi_rr), 32'd0);
        chk("late_aw_rel_fp", 32'(gv_fp), 32'd0);

        // rr_ptr 3: search 3 then 0. Early B and W-only do not advance.
        req = 4'b0001;
        grant_chk("sep", 0, 0);
        req = 4'b0000;
        b_hs = 1'b1;
        tick();
        chk("sep_early_b_valid", 32'(gv_rr), 32'd1);
        chk("sep_early_b_state", 32'(dut_rr.state_q), 32'd1);
        b_hs = 1'b0;
        w_hs = 1'b1;
        tick();
        w_hs = 1'b0;
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        chk("sep_w_only_valid", 32'(gv_rr), 32'd1);
        chk("sep_w_only_state", 32'(dut_rr.state_q), 32'd1);
        aw_hs = 1'b1;
        tick();
        aw_hs = 1'b0;
        chk("sep_resp", 32'(dut_rr.state_q), 32'd2);
        aw_hs = 1'b1;
        w_hs  = 1'b1;
        tick();
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        chk("sep_resp_hs_ignored", 32'(gv_rr), 32'd1);
        chk("sep_resp_hs_state", 32'(dut_rr.state_q), 32'd2);
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        chk("sep_rel", 32'(gv_rr), 32'd0);

        // rr_ptr 1: search 1,2,3 -> 3. Early B, then AW+W together.
        req = 4'b1000;
        grant_chk("early_b", 3, 3);
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        chk("early_b_ignored", 32'(gv_rr), 32'd1);
        aw_hs = 1'b1;
        w_hs  = 1'b1;
        tick();
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        chk("early_b_resp", 32'(dut_rr.state_q), 32'd2);
        tick();
        chk("early_b_wait_b", 32'(gv_rr), 32'd1);
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        chk("early_b_rel", 32'(gv_rr), 32'd0);

        // rr_ptr 0: grant 2, reach RESP, then reset asynchronously.
        req = 4'b0100;
        grant_chk("rst_mid", 2, 2);
        aw_hs = 1'b1;
        w_hs  = 1'b1;
        tick();
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        chk("rst_mid_grant", 32'(g_rr), 32'h4);
        chk("rst_mid_state", 32'(dut_rr.state_q), 32'd2);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_async_rr_grant", 32'(g_rr), 32'd0);
        chk("rst_async_rr_valid", 32'(gv_rr), 32'd0);
        chk("rst_async_fp_grant", 32'(g_fp), 32'd0);
        chk("rst_async_fp_valid", 32'(gv_fp), 32'd0);
        req = 4'b1111;
        tick();
        chk("rst_hold_no_grant", 32'(gv_rr), 32'd0);
        aresetn = 1'b1;
        #1;
        chk("rst_release_no_grant", 32'(gv_rr), 32'd0);
        grant_chk("after_rst", 0, 0);
        complete("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
